recur_seq_ctrl: RTL
===================

Name: recur_seq_ctrl

Overview:
Parametrised sequencer for the recursive-computation datapath. It drives register write-enable, write-select, operand-select and ALU-select for the loop a <- a*K (+ b), b <- b+1. It adds a start/busy/done handshake and a programmable iteration count. Loop termination comes either from the datapath zero flag or from an internal counter. It sits beside the datapath and register file, with one instance per computation engine.

Parameters:
CNT_W, 16, width of iteration count and internal counter
SEL_W, 2, width of wsel/osel/alusel fields
WAIT_CYC, 1, idle cycles after b update before termination check (1..15)

Ports:
clk  in  1  clock
res  in  1  synchronous reset, active-high
start  in  1  request new computation (sampled in IDLE/DONE)
term_sel  in  1  0: terminate on z; 1: terminate on internal counter
acc_b  in  1  1: loop adds b after multiply; 0: multiply only (geometric)
n_in  in  CNT_W  iteration count, latched on accepted start
z  in  1  datapath zero flag
wen  out  1  register-file write enable
wsel  out  SEL_W  write target: 00 a, 01 b, 10 n
osel  out  SEL_W  operand select: 00 a, 01 b, 10 n
alusel  out  SEL_W  00 inc, 01 add, 10 mul-by-K, 11 pass N
busy  out  1  high from accepted start until DONE
done  out  1  high while in DONE
iter_cnt  out  CNT_W  completed loop iterations

Behaviour:
- Reset: res=1 at posedge forces IDLE regardless of state. Outputs during and after reset: wen=0, wsel/osel=0, alusel=01, busy=0, done=0. iter_cnt and latched n cleared. Reset mid-loop aborts with no further writes.
- Moore outputs: every state drives all outputs defined (no X/Z). Next-state logic has a default arc to IDLE; no undriven encodings.
- States and outputs as {wen,wsel,osel,alusel}:
  - IDLE: 0_00_00_01
  - INIT_B (b<-1): 1_01_01_00
  - LOAD_N (n<-N): 1_10_00_11
  - INC_N (n<-n+1): 1_10_10_00
  - MUL (a<-a*K): 1_00_00_10
  - ADD (a<-a+b): 1_00_00_01
  - INC_B (b<-b+1): 1_01_01_00
  - WAIT: 0_00_00_01
  - DONE: 0_00_00_01
- Transitions:
  - IDLE --start--> INIT_B
  - INIT_B -> LOAD_N -> INC_N -> MUL
  - MUL -> ADD if acc_b=1, else MUL -> INC_B
  - ADD -> INC_B -> WAIT
  - WAIT stays WAIT_CYC cycles, then checks termination: true -> DONE, false -> MUL
  - DONE --start--> INIT_B; otherwise holds
- Start acceptance:
  - start is accepted only in IDLE or DONE and is ignored while busy.
  - On acceptance, n_in, term_sel and acc_b are latched; the live inputs are don't-care afterwards.
  - iter_cnt clears on acceptance.
- iter_cnt increments by 1 on each exit from WAIT. It saturates at all-ones and never wraps.
- Termination:
  - term_sel=0: z is sampled in the final WAIT cycle only.
  - term_sel=1: terminate when iter_cnt+1 == latched n.
- Edge case, latched n=0 with term_sel=1: INC_N goes directly to DONE (zero iterations, iter_cnt=0).
- Edge case, WAIT_CYC=1: WAIT is a single cycle.
- Latency: start to first MUL = 4 cycles. Each iteration = 3+WAIT_CYC cycles (acc_b=1) or 2+WAIT_CYC cycles (acc_b=0).
- busy=1 in INIT_B..WAIT; done=1 only in DONE; busy and done never high together.

Optional Feature:
- RECUR_ABORT_EN: adds input port abort (1 bit).
  - Defined: abort=1 in any busy state forces DONE at the next edge with wen=0 that cycle, and sets a sticky output aborted (1 bit), which clears on the next accepted start or reset. abort in IDLE/DONE has no effect. If res and abort are both high, res wins.
  - Undefined: neither port exists and behaviour is exactly as above.

Decomposition:
- Shared package recur_pkg:
  - state enum (IDLE, INIT_B, LOAD_N, INC_N, MUL, ADD, INC_B, WAIT, DONE)
  - WSEL_/OSEL_/ALU_ field constants
  - control-word typedef {wen,wsel,osel,alusel}
- One sub-module, recur_wait_timer: loadable WAIT_CYC down-counter with an expiry flag. Next-state and output decode stay in the top module.

Test Plan:
- Reset mid-MUL (res=1 for 1 cycle) -> next cycle IDLE, wen=0, busy=0, iter_cnt=0; no write in the reset cycle.
- start, term_sel=1, acc_b=1, n_in=3, WAIT_CYC=1 -> state sequence INIT_B,LOAD_N,INC_N,(MUL,ADD,INC_B,WAIT)x3,DONE; done at cycle 16; iter_cnt=3.
- term_sel=1, n_in=0 -> INIT_B,LOAD_N,INC_N,DONE; no MUL; iter_cnt=0.
- term_sel=0, acc_b=0, WAIT_CYC=2, z held 0 then 1 during the 2nd iteration's final WAIT cycle -> DONE after 2 iterations; a z pulse in the first WAIT cycle only is ignored.
- start pulsed while busy -> ignored; start in DONE with n_in=1 -> restart, done drops next cycle, iter_cnt cleared.
- RECUR_ABORT_EN: abort in ADD of iteration 2 -> DONE next cycle, aborted=1, no further wen; next start clears aborted.

Source files
------------

// File: rtl/recur_pkg.sv
// Shared types for the recursive-computation sequencer: state encoding,
// register/operand/ALU select constants and the per-state control word.
// Latency: n/a (types and a pure decode function). Backpressure: n/a.
package recur_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_B,
    S_LOAD_N,
    S_INC_N,
    S_MUL,
    S_ADD,
    S_INC_B,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] WSEL_A = 2'b00;
  localparam logic [1:0] WSEL_B = 2'b01;
  localparam logic [1:0] WSEL_N = 2'b10;

  localparam logic [1:0] OSEL_A = 2'b00;
  localparam logic [1:0] OSEL_B = 2'b01;
  localparam logic [1:0] OSEL_N = 2'b10;

  localparam logic [1:0] ALU_INC  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_MUL  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef struct packed {
    logic       wen;
    logic [1:0] wsel;
    logic [1:0] osel;
    logic [1:0] alusel;
  } ctrl_t;

  // Moore decode; anything not writing parks on the idle word (alusel=add).
  function automatic ctrl_t ctrl_of(input state_e s);
    case (s)
      S_INIT_B, S_INC_B: ctrl_of = '{1'b1, WSEL_B, OSEL_B, ALU_INC};
      S_LOAD_N:          ctrl_of = '{1'b1, WSEL_N, OSEL_A, ALU_PASS};
      S_INC_N:           ctrl_of = '{1'b1, WSEL_N, OSEL_N, ALU_INC};
      S_MUL:             ctrl_of = '{1'b1, WSEL_A, OSEL_A, ALU_MUL};
      S_ADD:             ctrl_of = '{1'b1, WSEL_A, OSEL_A, ALU_ADD};
      default:           ctrl_of = '{1'b0, WSEL_A, OSEL_A, ALU_ADD};
    endcase
  endfunction

  function automatic logic is_busy(input state_e s);
    is_busy = (s == S_INIT_B) || (s == S_LOAD_N) || (s == S_INC_N) ||
              (s == S_MUL) || (s == S_ADD) || (s == S_INC_B) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/recur_wait_timer.sv
// Loadable down-counter that times the idle cycles spent in WAIT.
// Latency: expired is registered, valid the cycle after load. Backpressure: none.
// Ports: clk/res (sync active-high), load (preset to WAIT_CYC-1), dec, expired.
module recur_wait_timer #(
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic res,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [3:0] cnt_q, cnt_d;

  // Preset to WAIT_CYC-1 so expired is already true in the last WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 4'(WAIT_CYC - 1);
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/recur_seq_ctrl.sv
// Sequencer for a <- a*K (+b), b <- b+1 with start/busy/done and iteration count.
// Latency: start to first MUL 4 cycles; iteration 3+WAIT_CYC (acc_b) or 2+WAIT_CYC.
// Backpressure: none; start is ignored while busy.
// Ports: clk, res (sync active-high), start, term_sel, acc_b, n_in, z in;
//        wen, wsel, osel, alusel, busy, done, iter_cnt out.
// Optional: RECUR_ABORT_EN adds input abort and sticky output aborted.
module recur_seq_ctrl #(
  parameter int CNT_W    = 16,
  parameter int SEL_W    = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             term_sel,
  input  logic             acc_b,
  input  logic [CNT_W-1:0] n_in,
  input  logic             z,
`ifdef RECUR_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             wen,
  output logic [SEL_W-1:0] wsel,
  output logic [SEL_W-1:0] osel,
  output logic [SEL_W-1:0] alusel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  import recur_pkg::*;

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             term_sel_q, term_sel_d;
  logic             acc_b_q, acc_b_d;
  logic             wait_exp;
  logic             term_hit;
`ifdef RECUR_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  recur_wait_timer #(.WAIT_CYC(WAIT_CYC)) u_wait_timer (
    .clk     (clk),
    .res     (res),
    .load    (state_q == S_INC_B),
    .dec     (state_q == S_WAIT),
    .expired (wait_exp)
  );

  // Extra bit keeps iter_cnt+1 from wrapping at all-ones.
  assign term_hit = term_sel_q ? (({1'b0, iter_cnt_q} + 1'b1) == {1'b0, n_q}) : z;

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    n_d        = n_q;
    term_sel_d = term_sel_q;
    acc_b_d    = acc_b_q;
`ifdef RECUR_ABORT_EN
    aborted_d  = aborted_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_INIT_B;
          n_d        = n_in;
          term_sel_d = term_sel;
          acc_b_d    = acc_b;
          iter_cnt_d = '0;
`ifdef RECUR_ABORT_EN
          aborted_d  = 1'b0;
`endif
        end
      end
      S_INIT_B: state_d = S_LOAD_N;
      S_LOAD_N: state_d = S_INC_N;
      // Counter mode with n=0 means zero iterations: skip the loop entirely.
      S_INC_N:  state_d = (term_sel_q && (n_q == '0)) ? S_DONE : S_MUL;
      S_MUL:    state_d = acc_b_q ? S_ADD : S_INC_B;
      S_ADD:    state_d = S_INC_B;
      S_INC_B:  state_d = S_WAIT;
      S_WAIT: begin
        if (wait_exp) begin
          if (iter_cnt_q != '1) begin
            iter_cnt_d = iter_cnt_q + 1'b1;
          end
          state_d = term_hit ? S_DONE : S_MUL;
        end
      end
      default:  state_d = S_IDLE;
    endcase
`ifdef RECUR_ABORT_EN
    if (abort && is_busy(state_q)) begin
      state_d   = S_DONE;
      aborted_d = 1'b1;
    end
`endif
    // Outputs are registered from the next state so they line up with state_q.
    ctrl_d = ctrl_of(state_d);
    busy_d = is_busy(state_d);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      ctrl_q     <= ctrl_of(S_IDLE);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iter_cnt_q <= '0;
      n_q        <= '0;
      term_sel_q <= 1'b0;
      acc_b_q    <= 1'b0;
`ifdef RECUR_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      iter_cnt_q <= iter_cnt_d;
      n_q        <= n_d;
      term_sel_q <= term_sel_d;
      acc_b_q    <= acc_b_d;
`ifdef RECUR_ABORT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  // Reset (and abort) suppress the write in the cycle they are asserted,
  // so a mid-loop abort never lands one more register update.
`ifdef RECUR_ABORT_EN
  assign wen     = ctrl_q.wen & ~res & ~abort;
  assign aborted = aborted_q;
`else
  assign wen     = ctrl_q.wen & ~res;
`endif
  assign wsel     = SEL_W'(ctrl_q.wsel);
  assign osel     = SEL_W'(ctrl_q.osel);
  assign alusel   = SEL_W'(ctrl_q.alusel);
  assign busy     = busy_q;
  assign done     = done_q;
  assign iter_cnt = iter_cnt_q;

endmodule
